// File: rtl/es7243e_i2c_target.sv
// I2C target with a 64-entry register file, modelling the ES7243E control port.
// Write: addr, pointer, data...; read: addr, data... with auto-increment pointer.
module es7243e_i2c_target #(
  parameter logic [6:0]  DEV_ADDR = 7'h10,
  parameter int unsigned DEPTH    = 64
) (
  input  logic       clk_12M,
  input  logic       rstn,
  input  logic       i2c_sclk,
  inout  wire        i2c_sdat,
  input  logic [5:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       wr_pulse,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] DEV       = 4'd1;
  localparam logic [3:0] DEV_ACK   = 4'd2;
  localparam logic [3:0] PTR       = 4'd3;
  localparam logic [3:0] PTR_ACK   = 4'd4;
  localparam logic [3:0] WDATA     = 4'd5;
  localparam logic [3:0] WDATA_ACK = 4'd6;
  localparam logic [3:0] RDATA     = 4'd7;
  localparam logic [3:0] RD_MACK   = 4'd8;
  localparam logic [3:0] WAIT_STOP = 4'd9;

  logic       scl_s1, scl_s2, scl_d, sda_s1, sda_s2, sda_d;
  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [3:0] state, state_nxt;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic [7:0] shreg, shreg_nxt;
  logic [7:0] ptr, ptr_nxt;
  logic       rw, rw_nxt;
  logic       sda_oe, sda_oe_nxt;
  logic       wr_pulse_nxt;
  logic [7:0] wr_addr_nxt, wr_data_nxt;
  logic       reg_we;
  logic       ptr_ok;
  logic [7:0] byte_c, rd_byte_c;
  logic [7:0] regs [DEPTH];

  // Bus synchronizers; idle-high reset values avoid false edges after reset
  always_ff @(posedge clk_12M or negedge rstn) begin
    if (!rstn) begin
      {scl_s1, scl_s2, scl_d} <= 3'b111;
      {sda_s1, sda_s2, sda_d} <= 3'b111;
    end else begin
      {scl_s1, scl_s2, scl_d} <= {i2c_sclk, scl_s1, scl_s2};
      {sda_s1, sda_s2, sda_d} <= {i2c_sdat, sda_s1, sda_s2};
    end
  end

  assign scl_rise  = scl_s2 & ~scl_d;
  assign scl_fall  = ~scl_s2 & scl_d;
  assign start_det = scl_s2 & sda_d & ~sda_s2;
  assign stop_det  = scl_s2 & ~sda_d & sda_s2;

  assign i2c_sdat  = sda_oe ? 1'b0 : 1'bz;
  assign rd_data   = regs[rd_addr];
  assign byte_c    = {shreg[6:0], sda_s2};
  assign ptr_ok    = (32'(ptr) < DEPTH);
  assign rd_byte_c = ptr_ok ? regs[ptr[AW-1:0]] : 8'hFF;

  // State and datapath registers
  always_ff @(posedge clk_12M or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      bit_cnt  <= 3'd0;
      shreg    <= 8'h00;
      ptr      <= 8'h00;
      rw       <= 1'b0;
      sda_oe   <= 1'b0;
      wr_pulse <= 1'b0;
      wr_addr  <= 8'h00;
      wr_data  <= 8'h00;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      bit_cnt  <= bit_cnt_nxt;
      shreg    <= shreg_nxt;
      ptr      <= ptr_nxt;
      rw       <= rw_nxt;
      sda_oe   <= sda_oe_nxt;
      wr_pulse <= wr_pulse_nxt;
      wr_addr  <= wr_addr_nxt;
      wr_data  <= wr_data_nxt;
      busy     <= (state_nxt != IDLE);
    end
  end

  always_ff @(posedge clk_12M or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= 8'h00;
    end else if (reg_we) begin
      regs[ptr[AW-1:0]] <= byte_c;
    end
  end

  // Next-state: START/STOP override all bit-level handling
  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    shreg_nxt    = shreg;
    ptr_nxt      = ptr;
    rw_nxt       = rw;
    sda_oe_nxt   = sda_oe;
    wr_pulse_nxt = 1'b0;
    wr_addr_nxt  = wr_addr;
    wr_data_nxt  = wr_data;
    reg_we       = 1'b0;

    if (start_det) begin
      state_nxt   = DEV;
      bit_cnt_nxt = 3'd0;
      sda_oe_nxt  = 1'b0;
    end else if (stop_det) begin
      state_nxt  = IDLE;
      sda_oe_nxt = 1'b0;
    end else begin
      case (state)
        DEV, PTR, WDATA: begin
          if (scl_rise) begin
            shreg_nxt   = byte_c;
            bit_cnt_nxt = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              case (state)
                DEV: begin
                  if (byte_c[7:1] == DEV_ADDR) begin
                    rw_nxt    = byte_c[0];
                    state_nxt = DEV_ACK;
                  end else begin
                    state_nxt = WAIT_STOP;
                  end
                end
                PTR: begin
                  ptr_nxt   = byte_c;
                  state_nxt = PTR_ACK;
                end
                default: begin
                  reg_we       = ptr_ok;
                  wr_pulse_nxt = 1'b1;
                  wr_addr_nxt  = ptr;
                  wr_data_nxt  = byte_c;
                  state_nxt    = WDATA_ACK;
                end
              endcase
            end
          end
        end
        DEV_ACK, PTR_ACK, WDATA_ACK: begin
          // First fall after the byte pulls SDA low; the next fall ends the slot
          if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe_nxt = 1'b1;
            end else begin
              sda_oe_nxt = 1'b0;
              case (state)
                DEV_ACK: begin
                  if (rw) begin
                    state_nxt  = RDATA;
                    shreg_nxt  = rd_byte_c;
                    sda_oe_nxt = ~rd_byte_c[7];
                  end else begin
                    state_nxt = PTR;
                  end
                end
                PTR_ACK: state_nxt = WDATA;
                default: begin
                  ptr_nxt   = ptr + 8'd1;
                  state_nxt = WDATA;
                end
              endcase
            end
          end
        end
        RDATA: begin
          if (scl_rise) begin
            bit_cnt_nxt = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state_nxt = RD_MACK;
          end else if (scl_fall) begin
            if (bit_cnt == 3'd0) begin
              shreg_nxt  = rd_byte_c;
              sda_oe_nxt = ~rd_byte_c[7];
            end else begin
              shreg_nxt  = {shreg[6:0], shreg[7]};
              sda_oe_nxt = ~shreg[6];
            end
          end
        end
        RD_MACK: begin
          if (scl_fall) begin
            sda_oe_nxt = 1'b0;
          end else if (scl_rise) begin
            if (!sda_s2) begin
              ptr_nxt     = ptr + 8'd1;
              bit_cnt_nxt = 3'd0;
              state_nxt   = RDATA;
            end else begin
              state_nxt = WAIT_STOP;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_es7243e_i2c_target.sv
// Bench for es7243e_i2c_target: bit-banged I2C master, transaction-level
// register/pointer model, directed table plus randomized transactions.
module tb_es7243e_i2c_target;

  localparam int Q = 6;  // clk per quarter SCL period (24x oversampling)

  logic       clk_12M = 1'b0;
  logic       rstn = 1'b0;
  logic       i2c_sclk = 1'b1;
  logic       m_oe = 1'b0;
  logic [5:0] rd_addr = 6'd0;
  logic [7:0] rd_data;
  logic       wr_pulse;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  wire        i2c_sdat;

  pullup (i2c_sdat);
  assign i2c_sdat = m_oe ? 1'b0 : 1'bz;

  es7243e_i2c_target dut (
    .clk_12M (clk_12M),
    .rstn    (rstn),
    .i2c_sclk(i2c_sclk),
    .i2c_sdat(i2c_sdat),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wr_pulse(wr_pulse),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy)
  );

  always #5 clk_12M = ~clk_12M;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wev_t;

  // mode 0: write (dev, ptr, data); 1: ptr write then Sr read; 2: current read
  typedef struct packed {
    logic [1:0]  mode;
    logic [7:0]  dev;
    logic [7:0]  ptr;
    logic [2:0]  n;
    logic [31:0] wd;
    logic        exp_ack;
    logic [31:0] exp_rd;
  } vec_t;

  wev_t       got_q[$];
  wev_t       exp_q[$];
  int         long_pulses = 0;
  logic       wp_prev = 1'b0;
  logic [7:0] mem [64];
  logic [7:0] mptr;

  always @(negedge clk_12M) begin
    if (wr_pulse) got_q.push_back({wr_addr, wr_data});
    if (wr_pulse && wp_prev) long_pulses++;
    wp_prev = wr_pulse;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic q(input int n);
    repeat (n * Q) @(posedge clk_12M);
  endtask

  // Reference model: whole transactions from the register-map rules
  task automatic model_txn(input logic [1:0] mode, input logic [7:0] dev, input logic [7:0] ptr,
                           input int n, input logic [31:0] wd,
                           output logic exp_ack, output logic [31:0] exp_rd);
    exp_rd = 32'h0;
    exp_ack = 1'b1;
    if (mode == 2'd0) begin
      if (dev != 8'h20) begin
        exp_ack = 1'b0;
        return;
      end
      mptr = ptr;
      for (int k = 0; k < n; k++) begin
        if (mptr < 8'd64) mem[mptr[5:0]] = wd[31-8*k -: 8];
        exp_q.push_back({mptr, wd[31-8*k -: 8]});
        mptr = mptr + 8'd1;
      end
    end else begin
      if (mode == 2'd1) mptr = ptr;
      for (int k = 0; k < n; k++) begin
        exp_rd[31-8*k -: 8] = (mptr < 8'd64) ? mem[mptr[5:0]] : 8'hFF;
        if (k < n - 1) mptr = mptr + 8'd1;
      end
    end
  endtask

  task automatic clock_bit(input logic b, output logic s);
    q(1); m_oe = ~b;
    q(1); i2c_sclk = 1'b1;
    q(1); s = (i2c_sdat !== 1'b0);
    q(1); i2c_sclk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
    clock_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] b, output logic slot);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s);
      b[i] = s;
    end
    clock_bit(~mack, slot);
  endtask

  task automatic start_c();
    if (!i2c_sclk) begin
      q(1); m_oe = 1'b0;
      q(1); i2c_sclk = 1'b1;
    end
    q(1); m_oe = 1'b1;
    q(1); i2c_sclk = 1'b0;
  endtask

  task automatic stop_c();
    q(1); m_oe = 1'b1;
    q(1); i2c_sclk = 1'b1;
    q(1); m_oe = 1'b0;
    q(2);
  endtask

  task automatic do_txn(input string nm, input logic [1:0] mode, input logic [7:0] dev,
                        input logic [7:0] ptr, input int n, input logic [31:0] wd,
                        input logic exp_ack, input logic [31:0] exp_rd);
    logic a, s;
    logic [7:0] b;
    start_c();
    send_byte((mode == 2'd2) ? 8'h21 : dev, a);
    chk({nm, " dev_ack"}, 32'(a), 32'(exp_ack));
    chk({nm, " busy_mid"}, 32'(busy), 32'd1);
    if (mode != 2'd2) begin
      send_byte(ptr, a);
      chk({nm, " ptr_ack"}, 32'(a), 32'(exp_ack));
    end
    if (mode == 2'd0) begin
      for (int k = 0; k < n; k++) begin
        send_byte(wd[31-8*k -: 8], a);
        chk($sformatf("%s data_ack%0d", nm, k), 32'(a), 32'(exp_ack));
      end
    end else begin
      if (mode == 2'd1) begin
        start_c();
        send_byte(8'h21, a);
        chk({nm, " rd_dev_ack"}, 32'(a), 32'd1);
      end
      for (int k = 0; k < n; k++) begin
        recv_byte(k < n - 1, b, s);
        chk($sformatf("%s rd_byte%0d", nm, k), 32'(b), 32'(exp_rd[31-8*k -: 8]));
        if (k == n - 1) chk({nm, " nack_slot_released"}, 32'(s), 32'd1);
      end
    end
    stop_c();
    chk({nm, " busy_after_stop"}, 32'(busy), 32'd0);
  endtask

  task automatic post_check(input string nm);
    chk({nm, " wr_pulse_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s wr_event%0d", nm, i), 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
    for (int a = 0; a < 64; a++) begin
      @(negedge clk_12M);
      rd_addr = 6'(a);
      #1;
      chk($sformatf("%s reg%02h", nm, a), 32'(rd_data), 32'(mem[a]));
    end
  endtask

  vec_t vt[8];

  initial begin
    logic        e_ack;
    logic [31:0] e_rd;
    logic        a, s;

    vt[0] = '{mode:2'd0, dev:8'h20, ptr:8'h0B, n:3'd1, wd:32'h0C000000, exp_ack:1'b1, exp_rd:32'h0};
    vt[1] = '{mode:2'd0, dev:8'h20, ptr:8'h17, n:3'd1, wd:32'h77000000, exp_ack:1'b1, exp_rd:32'h0};
    vt[2] = '{mode:2'd0, dev:8'h20, ptr:8'h14, n:3'd3, wd:32'h0C0C0200, exp_ack:1'b1, exp_rd:32'h0};
    vt[3] = '{mode:2'd2, dev:8'h21, ptr:8'h00, n:3'd1, wd:32'h0, exp_ack:1'b1, exp_rd:32'h77000000};
    vt[4] = '{mode:2'd1, dev:8'h20, ptr:8'h0B, n:3'd2, wd:32'h0, exp_ack:1'b1, exp_rd:32'h0C000000};
    vt[5] = '{mode:2'd0, dev:8'h28, ptr:8'h01, n:3'd0, wd:32'h0, exp_ack:1'b0, exp_rd:32'h0};
    vt[6] = '{mode:2'd0, dev:8'h20, ptr:8'hF9, n:3'd1, wd:32'h01000000, exp_ack:1'b1, exp_rd:32'h0};
    vt[7] = '{mode:2'd1, dev:8'h20, ptr:8'hFF, n:3'd2, wd:32'h0, exp_ack:1'b1, exp_rd:32'hFF000000};

    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    mptr = 8'h00;

    // Reset state
    repeat (5) @(posedge clk_12M);
    @(negedge clk_12M);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst wr_pulse", 32'(wr_pulse), 32'd0);
    chk("rst wr_addr", 32'(wr_addr), 32'd0);
    chk("rst wr_data", 32'(wr_data), 32'd0);
    chk("rst sda_released", 32'(i2c_sdat !== 1'b0), 32'd1);
    rstn = 1'b1;
    q(2);
    post_check("rst");

    // Directed table
    for (int i = 0; i < 8; i++) begin
      model_txn(vt[i].mode, vt[i].dev, vt[i].ptr, int'(vt[i].n), vt[i].wd, e_ack, e_rd);
      do_txn($sformatf("vec%0d", i), vt[i].mode, vt[i].dev, vt[i].ptr, int'(vt[i].n),
             vt[i].wd, vt[i].exp_ack, vt[i].exp_rd);
      post_check($sformatf("vec%0d", i));
    end

    // Randomized transactions against the model
    for (int i = 0; i < 16; i++) begin
      logic [1:0]  md;
      logic [7:0]  dv, pt;
      int          nb;
      logic [31:0] wd;
      md = 2'($urandom_range(0, 2));
      dv = 8'h20;
      if (md == 2'd0 && $urandom_range(0, 5) == 0) begin
        dv = {7'($urandom_range(0, 127)), 1'b0};
        if (dv == 8'h20) dv = 8'h22;
      end
      pt = ($urandom_range(0, 3) == 0) ? 8'(250 + $urandom_range(0, 5)) : 8'($urandom_range(0, 63));
      nb = $urandom_range(1, 4);
      wd = $urandom;
      model_txn(md, dv, pt, nb, wd, e_ack, e_rd);
      do_txn($sformatf("rnd%0d", i), md, dv, pt, nb, wd, e_ack, e_rd);
      post_check($sformatf("rnd%0d", i));
    end

    // Make sure the reset test below has something to clear
    model_txn(2'd0, 8'h20, 8'h0B, 1, 32'hA5000000, e_ack, e_rd);
    do_txn("preload", 2'd0, 8'h20, 8'h0B, 1, 32'hA5000000, e_ack, e_rd);
    post_check("preload");

    // Reset in the 4th bit of a data byte, then traffic without START
    start_c();
    send_byte(8'h20, a);
    send_byte(8'h0B, a);
    for (int i = 0; i < 3; i++) clock_bit(1'b1, s);
    q(1); m_oe = 1'b0;
    q(1); i2c_sclk = 1'b1;
    q(1);
    chk("mrst busy_before", 32'(busy), 32'd1);
    rstn = 1'b0;
    #1;
    chk("mrst sda_released", 32'(i2c_sdat !== 1'b0), 32'd1);
    chk("mrst busy", 32'(busy), 32'd0);
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    mptr = 8'h00;
    exp_q.delete();
    got_q.delete();
    post_check("mrst in_reset");
    q(1); i2c_sclk = 1'b0;
    q(1); rstn = 1'b1;
    for (int i = 0; i < 4; i++) clock_bit(1'b0, s);
    clock_bit(1'b1, s);
    chk("mrst ack_slot_released", 32'(s), 32'd1);
    send_byte(8'h55, a);
    chk("mrst no_ack", 32'(a), 32'd0);
    chk("mrst busy_ignored", 32'(busy), 32'd0);
    stop_c();
    post_check("mrst after");

    // Back to normal operation: pointer restarts at 0
    model_txn(2'd0, 8'h20, 8'h3F, 2, 32'h5AC30000, e_ack, e_rd);
    do_txn("resume_wr", 2'd0, 8'h20, 8'h3F, 2, 32'h5AC30000, e_ack, e_rd);
    post_check("resume_wr");
    model_txn(2'd1, 8'h20, 8'h3F, 2, 32'h0, e_ack, e_rd);
    do_txn("resume_rd", 2'd1, 8'h20, 8'h3F, 2, 32'h0, e_ack, e_rd);
    post_check("resume_rd");

    chk("wr_pulse single_cycle", 32'(long_pulses), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
